axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_pkg.sv | 21 ++
 rtl/sram_bank.sv | 27 ++
 rtl/axi_sram_slave.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, response/burst codes and slave FSM states.
// AXI_IDS_BITS defaults to 8 when no AXI_define.svh has set it.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] INCR   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

endpackage

// File: rtl/sram_bank.sv
// sram_bank: single-port word memory, byte write enables,
// registered read data that only changes on a read access.
module sram_bank #(
  parameter int WORDS = 16384,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wr,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (en && !wr) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: one-transaction-at-a-time AXI slave over sram_bank.
// Define AXI_SRAM_SLAVE_ERR_CHK_EN to flag non-INCR bursts / bad WLAST.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int MEM_WORDS = 16384,
  parameter int ID_W      = `AXI_IDS_BITS
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic [ID_W-1:0] AWID,
  input  logic [31:0]     AWADDR,
  input  logic [3:0]      AWLEN,
  input  logic [2:0]      AWSIZE,
  input  logic [1:0]      AWBURST,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [31:0]     WDATA,
  input  logic [3:0]      WSTRB,
  input  logic            WLAST,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [ID_W-1:0] BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [ID_W-1:0] ARID,
  input  logic [31:0]     ARADDR,
  input  logic [3:0]      ARLEN,
  input  logic [2:0]      ARSIZE,
  input  logic [1:0]      ARBURST,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [ID_W-1:0] RID,
  output logic [31:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST,
  output logic            RVALID,
  input  logic            RREADY
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t          state, state_n;
  logic            prio_rd;
  logic [ID_W-1:0] id_q;
  logic [29:0]     addr_q;
  logic [3:0]      len_q, cnt_q;
  logic            err_q;

  logic        idle, aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic        last_beat, w_err, set_err;
  logic [31:0] mem_rdata;
  logic        unused;

  assign idle  = (state == S_IDLE) && !ARESET;
  assign ar_hs = idle && ARVALID && (prio_rd || !AWVALID);
  assign aw_hs = idle && AWVALID && !ar_hs;

  assign ARREADY = ar_hs;
  assign AWREADY = aw_hs;
  assign WREADY  = (state == S_WDATA) && !ARESET;
  assign BVALID  = (state == S_WRESP) && !ARESET;
  assign RVALID  = (state == S_RDATA) && !ARESET;

  assign w_hs = WREADY && WVALID;
  assign b_hs = BVALID && BREADY;
  assign r_hs = RVALID && RREADY;

  assign last_beat = (cnt_q == len_q);

  assign BID   = BVALID ? id_q : '0;
  assign BRESP = (BVALID && err_q) ? SLVERR : OKAY;
  assign RID   = RVALID ? id_q : '0;
  assign RRESP = (RVALID && err_q) ? SLVERR : OKAY;
  assign RLAST = RVALID && last_beat;
  assign RDATA = (RVALID && !err_q) ? mem_rdata : '0;

`ifdef AXI_SRAM_SLAVE_ERR_CHK_EN
  assign w_err   = w_hs && (WLAST != last_beat);
  assign set_err = (aw_hs && (AWBURST != INCR))
                || (ar_hs && (ARBURST != INCR))
                || w_err;
  assign unused  = ^{AWSIZE, ARSIZE, AWADDR[1:0],
                     ARADDR[1:0], addr_q};
`else
  assign w_err   = 1'b0;
  assign set_err = 1'b0;
  assign unused  = ^{AWSIZE, ARSIZE, AWADDR[1:0],
                     ARADDR[1:0], addr_q, WLAST,
                     AWBURST, ARBURST};
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (ar_hs)      state_n = S_RADDR;
        else if (aw_hs) state_n = S_WDATA;
      end
      S_WDATA: if (w_hs && last_beat) state_n = S_WRESP;
      S_WRESP: if (b_hs) state_n = S_IDLE;
      S_RADDR: state_n = S_RDATA;
      S_RDATA: begin
        if (r_hs) state_n = last_beat ? S_IDLE : S_RADDR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      prio_rd <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_q    <= AWID;
        addr_q  <= AWADDR[31:2];
        len_q   <= AWLEN;
        cnt_q   <= '0;
        prio_rd <= 1'b1;
        err_q   <= set_err;
      end
      if (ar_hs) begin
        id_q    <= ARID;
        addr_q  <= ARADDR[31:2];
        len_q   <= ARLEN;
        cnt_q   <= '0;
        prio_rd <= 1'b0;
        err_q   <= set_err;
      end
      if (w_hs || (r_hs && !last_beat)) begin
        addr_q <= addr_q + 30'd1;
        cnt_q  <= cnt_q + 4'd1;
      end
      if (w_err) err_q <= 1'b1;
    end
  end

  // a flagged transaction keeps counting beats but never writes
  sram_bank #(.WORDS(MEM_WORDS), .AW(AW)) u_bank (
    .clk   (ACLK),
    .en    (w_hs || (state == S_RADDR)),
    .wr    (w_hs),
    .be    ((err_q || w_err) ? 4'b0000 : WSTRB),
    .addr  (addr_q[AW-1:0]),
    .wdata (WDATA),
    .rdata (mem_rdata)
  );

endmodule
